id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register for the 5-stage RV32I core. Captures the decoded control bundle
//   {RegWrite, MemRead, MemWrite, Branch, ALUSrc, ALUOp, MemToReg} from the decoder, plus
//   operands and register fields, and presents them to EX one cycle later.
//   Owns load-use hazard detection: stalls PC/IF-ID and inserts a bubble into EX.
//   Squashes the ID-stage instruction on a taken-branch flush.
// PARAMETERS
//   XLEN    32  datapath width (operands, immediate, PC)
//   RA_W    5   register address width
//   CNT_W   16  width of saturating stall/flush event counters
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   flush_i       in   1      taken branch resolved in EX; kill the instruction in ID
//   id_valid_i    in   1      ID holds a real instruction
//   id_ctrl_i     in   8      {RegWrite,MemRead,MemWrite,Branch,ALUSrc,ALUOp[1:0],MemToReg}
//   id_pc_i       in   XLEN   PC of ID instruction
//   id_rs1_data_i in   XLEN   register-file read data, port 1
//   id_rs2_data_i in   XLEN   register-file read data, port 2
//   id_imm_i      in   XLEN   sign-extended immediate
//   id_rs1_i      in   RA_W   source register 1 index
//   id_rs2_i      in   RA_W   source register 2 index
//   id_rd_i       in   RA_W   destination register index
//   id_use_rs1_i  in   1      instruction reads rs1
//   id_use_rs2_i  in   1      instruction reads rs2
//   id_funct_i    in   4      {funct7[5],funct3} for ALU control
//   stall_o       out  1      hold PC and IF/ID this cycle (combinational)
//   ex_valid_o    out  1      EX holds a real instruction
//   ex_ctrl_o     out  8      registered control bundle, same bit order as id_ctrl_i
//   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out XLEN  registered copies
//   ex_rs1_o, ex_rs2_o, ex_rd_o  out RA_W  registered copies
//   ex_funct_o    out  4      registered copy
//   stall_cnt_o   out  CNT_W  number of load-use bubbles inserted (saturating)
//   flush_cnt_o   out  CNT_W  number of valid ID instructions squashed (saturating)
// BEHAVIOUR
//   Reset (async, rst_n=0): all ex_* outputs and both counters go to 0; ex_valid_o=0.
//     stall_o is still computed combinationally, so it is 0 while ex_valid_o=0.
//   Hazard (combinational):
//     hz = ex_valid_o & ex_ctrl_o[MemRead] & (ex_rd_o!=0) & id_valid_i &
//          ((id_use_rs1_i & id_rs1_i==ex_rd_o) | (id_use_rs2_i & id_rs2_i==ex_rd_o)).
//     stall_o = hz & ~flush_i.
//   Per rising clk edge, priority flush > bubble > advance:
//     flush_i=1     : ex_valid_o<=0, ex_ctrl_o<=0; data fields are don't-care (hold).
//                     flush_cnt_o += 1 if id_valid_i.
//     hz, no flush  : bubble. ex_valid_o<=0, ex_ctrl_o<=0; stall_cnt_o += 1.
//                     The ID instruction is re-presented next cycle by the held IF/ID.
//     otherwise     : all ex_* <= id_* ; ex_valid_o <= id_valid_i;
//                     ex_ctrl_o <= id_valid_i ? id_ctrl_i : 0.
//   Latency: exactly 1 cycle ID->EX. A load-use pair costs exactly 1 bubble.
//     After the bubble, EX holds no load, so hz=0 and the dependent instruction advances.
//   Invalid entries always carry ex_ctrl_o=0, so there are no stray RegWrite/MemWrite.
//   Counters saturate at 2^CNT_W-1 and never wrap.
//   Reset asserted mid-stall: outputs clear immediately; stall_o drops because ex_valid_o=0.
//   rd=x0 load never stalls.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> all ex_* = 0, stall_o=0, counters 0, without waiting for clk.
//   2 Pass-through: ADDI x5 (ctrl 8'b1000_1000, imm=7) -> next cycle ex_ctrl_o=8'h88,
//     ex_imm_o=7, ex_rd_o=5, ex_valid_o=1.
//   3 Load-use: LW x3 in EX, ADD x4,x3,x2 in ID -> stall_o=1 for 1 cycle, EX bubble ctrl=0,
//     then ADD in EX; stall_cnt_o=1.
//   4 No false stall: LW x0 in EX with rs1=0; also LW x3 followed by ADDI using only rs1=x2
//     -> stall_o=0 in both cases.
//   5 Flush beats hazard: load-use condition with flush_i=1 -> stall_o=0, ex_valid_o=0 next
//     cycle, flush_cnt_o=1, stall_cnt_o unchanged.
//   6 Saturation: CNT_W=2, force 5 bubbles -> stall_cnt_o sticks at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards, inserts bubbles and squashes ID on branch flush.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [7:0]       id_ctrl_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [3:0]       id_funct_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [7:0]       ex_ctrl_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [RA_W-1:0]  ex_rs1_o,
  output logic [RA_W-1:0]  ex_rs2_o,
  output logic [RA_W-1:0]  ex_rd_o,
  output logic [3:0]       ex_funct_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int MEMREAD = 6;

  logic             r_valid;
  logic [7:0]       r_ctrl;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [RA_W-1:0]  r_rs1;
  logic [RA_W-1:0]  r_rs2;
  logic [RA_W-1:0]  r_rd;
  logic [3:0]       r_funct;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_src_hit;
  logic w_hz;

  assign w_src_hit = (id_use_rs1_i && id_rs1_i == r_rd)
                   || (id_use_rs2_i && id_rs2_i == r_rd);

  assign w_hz = r_valid && r_ctrl[MEMREAD] && (r_rd != '0)
             && id_valid_i && w_src_hit;

  assign stall_o = w_hz && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_funct     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (id_valid_i && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (w_hz) begin
      // bubble; IF/ID is held so the consumer re-presents next cycle
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_valid    <= id_valid_i;
      r_ctrl     <= id_valid_i ? id_ctrl_i : 8'h00;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_funct    <= id_funct_i;
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_ctrl_o     = r_ctrl;
  assign ex_pc_o       = r_pc;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_rs1_o      = r_rs1;
  assign ex_rs2_o      = r_rs2;
  assign ex_rd_o       = r_rd;
  assign ex_funct_o    = r_funct;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic
// against a transaction-level model of the EX slot and event counts.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [7:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1d, id_rs2d, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        use1, use2;
  logic [3:0]  id_funct;

  logic        stall, ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [15:0] scnt, fcnt;

  logic        s_stall, s_valid;
  logic [7:0]  s_ctrl;
  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_funct;
  logic [1:0]  s_scnt, s_fcnt;

  int checks = 0;
  int failures = 0;

  // model of what EX holds
  bit        m_valid;
  bit [7:0]  m_ctrl;
  bit [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  bit [4:0]  m_rs1, m_rs2, m_rd;
  bit [3:0]  m_funct;
  int        m_scnt, m_fcnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .id_valid_i(id_valid), .id_ctrl_i(id_ctrl), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d),
    .id_imm_i(id_imm), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rd_i(id_rd), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .id_funct_i(id_funct), .stall_o(stall), .ex_valid_o(ex_valid),
    .ex_ctrl_o(ex_ctrl), .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1d),
    .ex_rs2_data_o(ex_rs2d), .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1),
    .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_funct_o(ex_funct),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .id_valid_i(id_valid), .id_ctrl_i(id_ctrl), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d),
    .id_imm_i(id_imm), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rd_i(id_rd), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .id_funct_i(id_funct), .stall_o(s_stall), .ex_valid_o(s_valid),
    .ex_ctrl_o(s_ctrl), .ex_pc_o(s_pc), .ex_rs1_data_o(s_rs1d),
    .ex_rs2_data_o(s_rs2d), .ex_imm_o(s_imm), .ex_rs1_o(s_rs1),
    .ex_rs2_o(s_rs2), .ex_rd_o(s_rd), .ex_funct_o(s_funct),
    .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  // load in EX whose nonzero rd is read by a valid ID instruction
  function automatic bit model_hz();
    return m_valid && m_ctrl[6] && m_rd != 0 && id_valid &&
           ((use1 && id_rs1 == m_rd) || (use2 && id_rs2 == m_rd));
  endfunction

  task automatic set_id(bit v, bit [7:0] c, bit [4:0] rs1, bit [4:0] rs2,
                        bit [4:0] rd, bit u1, bit u2, bit [31:0] imm);
    id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    use1 = u1; use2 = u2; id_imm = imm;
    id_pc = $urandom; id_rs1d = $urandom; id_rs2d = $urandom;
    id_funct = 4'($urandom);
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0;
    m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // one clock: advance DUT and model, return #1 after the edge
  task automatic cycle();
    bit hz;
    hz = model_hz();
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_ctrl = 0;
      if (id_valid) m_fcnt++;
    end else if (hz) begin
      m_valid = 0; m_ctrl = 0; m_scnt++;
    end else begin
      m_valid = id_valid;
      m_ctrl = id_valid ? id_ctrl : 8'h00;
      m_pc = id_pc; m_rs1d = id_rs1d; m_rs2d = id_rs2d; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
    end
    #1;
  endtask

  task automatic test_pass_through();
    do_reset();
    flush = 0;
    set_id(1, 8'h88, 5'd1, 5'd0, 5'd5, 1, 0, 32'd7);
    cycle();
    checks++;
    if (ex_ctrl !== 8'h88 || ex_imm !== 32'd7 || ex_rd !== 5'd5
        || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL pass_through ctrl=%h imm=%0d rd=%0d v=%b want 88/7/5/1",
               ex_ctrl, ex_imm, ex_rd, ex_valid);
    end
    checks++;
    if (ex_pc !== m_pc || ex_rs1d !== m_rs1d || ex_rs2d !== m_rs2d
        || ex_funct !== m_funct) begin
      failures++;
      $display("FAIL pass_through_data pc=%h want %h", ex_pc, m_pc);
    end
  endtask

  task automatic test_load_use();
    int s0;
    do_reset();
    flush = 0;
    s0 = m_scnt;
    set_id(1, 8'hC1, 5'd1, 5'd0, 5'd3, 1, 0, 32'd0);
    cycle();
    set_id(1, 8'h84, 5'd3, 5'd2, 5'd4, 1, 1, 32'd0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall stall=%b want 1", stall);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall !== 1'b0) begin
      failures++;
      $display("FAIL load_use_bubble v=%b ctrl=%h stall=%b want 0/00/0",
               ex_valid, ex_ctrl, stall);
    end
    checks++;
    if (scnt !== 16'(s0 + 1)) begin
      failures++;
      $display("FAIL load_use_cnt got=%0d want=%0d", scnt, s0 + 1);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b1 || ex_ctrl !== 8'h84 || ex_rd !== 5'd4) begin
      failures++;
      $display("FAIL load_use_adv v=%b ctrl=%h rd=%0d want 1/84/4",
               ex_valid, ex_ctrl, ex_rd);
    end
  endtask

  task automatic test_no_false_stall();
    do_reset();
    flush = 0;
    set_id(1, 8'hC1, 5'd1, 5'd0, 5'd0, 1, 0, 32'd0);
    cycle();
    set_id(1, 8'h88, 5'd0, 5'd0, 5'd6, 1, 0, 32'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL no_stall_x0 stall=%b want 0", stall);
    end
    set_id(1, 8'hC1, 5'd1, 5'd0, 5'd3, 1, 0, 32'd0);
    cycle();
    set_id(1, 8'h88, 5'd2, 5'd3, 5'd6, 1, 0, 32'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL no_stall_rs2_unused stall=%b want 0", stall);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || scnt !== 16'd0) begin
      failures++;
      $display("FAIL no_stall_adv v=%b rd=%0d scnt=%0d want 1/6/0",
               ex_valid, ex_rd, scnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 0;
    set_id(1, 8'hC1, 5'd1, 5'd0, 5'd3, 1, 0, 32'd0);
    cycle();
    set_id(1, 8'h84, 5'd3, 5'd2, 5'd4, 1, 1, 32'd0);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall stall=%b want 0", stall);
    end
    cycle();
    flush = 0;
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || fcnt !== 16'd1
        || scnt !== 16'd0) begin
      failures++;
      $display("FAIL flush_beats_hz v=%b ctrl=%h f=%0d s=%0d want 0/00/1/0",
               ex_valid, ex_ctrl, fcnt, scnt);
    end
  endtask

  task automatic test_reset();
    flush = 0;
    set_id(1, 8'hC1, 5'd1, 5'd0, 5'd9, 1, 0, 32'd0);
    cycle();
    set_id(1, 8'h84, 5'd9, 5'd2, 5'd4, 1, 1, 32'd0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_stall stall=%b want 1", stall);
    end
    #1;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_ctrl !== 8'h00
        || ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_rd !== 5'd0
        || ex_rs1d !== 32'd0 || ex_rs2d !== 32'd0 || ex_rs1 !== 5'd0
        || ex_rs2 !== 5'd0 || ex_funct !== 4'd0) begin
      failures++;
      $display("FAIL reset_async stall=%b v=%b ctrl=%h pc=%h rd=%0d",
               stall, ex_valid, ex_ctrl, ex_pc, ex_rd);
    end
    checks++;
    if (scnt !== 16'd0 || fcnt !== 16'd0 || s_scnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt s=%0d f=%0d want 0/0", scnt, fcnt);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    flush = 0;
    for (int i = 0; i < 5; i++) begin
      set_id(1, 8'hC1, 5'd1, 5'd0, 5'd3, 1, 0, 32'd0);
      cycle();
      set_id(1, 8'h84, 5'd2, 5'd3, 5'd4, 1, 1, 32'd0);
      cycle();
      cycle();
    end
    checks++;
    if (s_scnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_small got=%0d want=3", s_scnt);
    end
    checks++;
    if (scnt !== 16'd5) begin
      failures++;
      $display("FAIL sat_wide got=%0d want=5", scnt);
    end
  endtask

  task automatic test_random();
    bit exp_st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 5) != 0), 8'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom);
      if ($urandom_range(0, 2) == 0) id_ctrl[6] = 1'b1;
      flush = ($urandom_range(0, 7) == 0);
      #1;
      exp_st = model_hz() && !flush;
      checks++;
      if (stall !== exp_st || s_stall !== exp_st) begin
        failures++;
        $display("FAIL rnd_stall i=%0d got=%b want=%b", i, stall, exp_st);
      end
      cycle();
      checks++;
      if (ex_valid !== m_valid || ex_ctrl !== m_ctrl) begin
        failures++;
        $display("FAIL rnd_ex i=%0d v=%b ctrl=%h want %b/%h",
                 i, ex_valid, ex_ctrl, m_valid, m_ctrl);
      end
      if (m_valid) begin
        checks++;
        if (ex_pc !== m_pc || ex_rs1d !== m_rs1d || ex_rs2d !== m_rs2d
            || ex_imm !== m_imm || ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2
            || ex_rd !== m_rd || ex_funct !== m_funct) begin
          failures++;
          $display("FAIL rnd_data i=%0d pc=%h rd=%0d want %h/%0d",
                   i, ex_pc, ex_rd, m_pc, m_rd);
        end
      end
      checks++;
      if (scnt !== 16'(sat(m_scnt, 65535)) || fcnt !== 16'(sat(m_fcnt, 65535))
          || s_scnt !== 2'(sat(m_scnt, 3)) || s_fcnt !== 2'(sat(m_fcnt, 3)))
      begin
        failures++;
        $display("FAIL rnd_cnt i=%0d s=%0d f=%0d ss=%0d sf=%0d want %0d/%0d",
                 i, scnt, fcnt, s_scnt, s_fcnt, m_scnt, m_fcnt);
      end
    end
    flush = 0;
  endtask

  initial begin
    rst_n = 0;
    flush = 0;
    set_id(0, 8'h00, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0);
    model_reset();
    #12;
    rst_n = 1;
    test_pass_through();
    test_load_use();
    test_reset();
    test_no_false_stall();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
